// File: rtl/tinyqv_time_prescaler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tinyqv_time_pkg: shared encodings and field positions for the        |
// | TinyQV 1 MHz time prescaler.                  Revision: 1.0          |
// +----------------------------------------------------------------------+
package tinyqv_time_pkg;

  typedef enum logic [1:0] {
    MODE_INTERNAL = 2'b00,
    MODE_EXTERNAL = 2'b01,
    MODE_STOPPED  = 2'b10
  } mode_e;

  localparam int CFG_MODE_HI = 31;
  localparam int CFG_MODE_LO = 30;
  localparam int CFG_LOST    = 29;
  localparam int CFG_DIV_HI  = 23;
  localparam int CFG_DIV_LO  = 8;
  localparam int CFG_FRAC_HI = 7;
  localparam int CFG_FRAC_LO = 0;

  localparam logic [15:0] DIV_MIN    = 16'd2;
  localparam logic [1:0]  MISS_LIMIT = 2'd2;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tinyqv_time_prescaler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tinyqv_time_prescaler_if: config bus and timer strobe of the         |
// | prescaler.                                    Revision: 1.0          |
// +----------------------------------------------------------------------+
interface tinyqv_time_prescaler_if;
  logic        set_cfg;
  logic [31:0] data_in;
  logic [31:0] cfg_out;
  logic        ext_lost;
  logic        time_pulse;

  modport master (output set_cfg, data_in, input cfg_out, ext_lost, time_pulse);
  modport slave  (input set_cfg, data_in, output cfg_out, ext_lost, time_pulse);
endinterface
`default_nettype wire

// File: rtl/tinyqv_time_prescaler_pulse_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tinyqv_pulse_sync: 2-flop synchroniser with registered rising-edge   |
// | detect, one-cycle output.                     Revision: 1.0          |
// +----------------------------------------------------------------------+
module tinyqv_pulse_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic sync1, sync2, sync2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
      pulse   <= sync2 & ~sync2_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tinyqv_time_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tinyqv_time_prescaler: 1 MHz mtime strobe from a fractional divider  |
// | or an external reference with watchdog fallback.  Revision: 1.0      |
// +----------------------------------------------------------------------+
module tinyqv_time_prescaler
  import tinyqv_time_pkg::*;
#(
  parameter int DEFAULT_DIV_INT  = 64,
  parameter int DEFAULT_DIV_FRAC = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ext_ref,
  tinyqv_time_prescaler_if.slave  bus
);

  localparam logic [15:0] RST_DIV_INT  = 16'(DEFAULT_DIV_INT);
  localparam logic [7:0]  RST_DIV_FRAC = 8'(DEFAULT_DIV_FRAC);

  logic [1:0]  mode;
  logic [15:0] div_int;
  logic [7:0]  div_frac;
  logic [15:0] cnt;
  logic [7:0]  acc;
  logic [1:0]  miss;
  logic        ext_lost;
  logic        fallback;
  logic        time_pulse;

  logic        ref_edge;
  logic        wrap;
  logic        is_ext;
  logic        is_stop;
  logic [8:0]  acc_sum;
  logic [15:0] new_div;
  logic [1:0]  miss_next;
  logic        lost_now;
  logic        pulse_req;
  logic        unused_bits;

  tinyqv_pulse_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ext_ref),
    .pulse    (ref_edge)
  );

  assign wrap      = (cnt == 16'd0);
  assign is_ext    = (mode == MODE_EXTERNAL);
  assign is_stop   = mode[1];  // both 10 and 11 mean stopped
  assign acc_sum   = {1'b0, acc} + {1'b0, div_frac};
  assign new_div   = clamp_div(bus.data_in[CFG_DIV_HI:CFG_DIV_LO]);
  assign miss_next = (miss == MISS_LIMIT) ? miss : miss + 2'd1;
  assign lost_now  = is_ext & wrap & ~ref_edge & (miss_next == MISS_LIMIT);
  assign unused_bits = ^bus.data_in[28:24];

  always_comb begin
    pulse_req = 1'b0;
    if (bus.set_cfg || is_stop) begin
      pulse_req = 1'b0;
    end else if (is_ext) begin
      pulse_req = ref_edge | (wrap & (fallback | lost_now));
    end else begin
      pulse_req = wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= MODE_INTERNAL;
      div_int    <= RST_DIV_INT;
      div_frac   <= RST_DIV_FRAC;
      cnt        <= RST_DIV_INT - 16'd1;
      acc        <= 8'd0;
      miss       <= 2'd0;
      ext_lost   <= 1'b0;
      fallback   <= 1'b0;
      time_pulse <= 1'b0;
    end else begin
      // Guard keeps the strobe single-cycle when an edge follows a wrap pulse.
      time_pulse <= pulse_req & ~time_pulse;
      if (bus.set_cfg) begin
        mode     <= bus.data_in[CFG_MODE_HI:CFG_MODE_LO];
        div_int  <= new_div;
        div_frac <= bus.data_in[CFG_FRAC_HI:CFG_FRAC_LO];
        cnt      <= new_div - 16'd1;
        acc      <= 8'd0;
        miss     <= 2'd0;
        ext_lost <= 1'b0;
        fallback <= 1'b0;
      end else if (is_stop) begin
        cnt <= div_int - 16'd1;
        acc <= 8'd0;
      end else if (is_ext && ref_edge) begin
        cnt      <= div_int - 16'd1;
        acc      <= 8'd0;
        miss     <= 2'd0;
        fallback <= 1'b0;
      end else if (wrap) begin
        acc <= acc_sum[7:0];
        cnt <= div_int - 16'd1 + {15'd0, acc_sum[8]};
        if (is_ext) begin
          miss <= miss_next;
        end
        if (lost_now) begin
          fallback <= 1'b1;
          ext_lost <= 1'b1;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  assign bus.cfg_out    = {mode, ext_lost, 5'b0, div_int, div_frac};
  assign bus.ext_lost   = ext_lost;
  assign bus.time_pulse = time_pulse;

endmodule
`default_nettype wire

// File: tb/tb_tinyqv_time_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tinyqv_time_prescaler: scoreboard bench, expected pulse cycles    |
// | queued by stimulus and consumed by a pulse monitor. Revision: 1.0    |
// +----------------------------------------------------------------------+
module tb_tinyqv_time_prescaler;

  logic clk;
  logic rst;
  logic ext_ref;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_q[$];
  logic prev_pulse = 1'b0;

  tinyqv_time_prescaler_if bus ();

  tinyqv_time_prescaler #(
    .DEFAULT_DIV_INT  (64),
    .DEFAULT_DIV_FRAC (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ext_ref (ext_ref),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.time_pulse) begin
      checks++;
      if (prev_pulse) begin
        failures++;
        $display("FAIL consecutive: pulse high at cycle %0d and %0d", cyc - 1, cyc);
      end
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_pulse: none at cycle %0d, next seen at %0d", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: pulse at cycle %0d, expected none", cyc);
      end else if (exp_q[0] != cyc) begin
        failures++;
        $display("FAIL pulse_time: pulse at cycle %0d, expected %0d", cyc, exp_q[0]);
      end else begin
        void'(exp_q.pop_front());
      end
    end
    prev_pulse = bus.time_pulse;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int last);
    wait_until(last + 1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending pulses (next %0d) required 0", exp_q.size(), exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic cfg_write(input logic [31:0] data, input logic [31:0] exp, output int k);
    k = cyc + 1;
    bus.set_cfg = 1'b1;
    bus.data_in = data;
    @(posedge clk);
    #1;
    bus.set_cfg = 1'b0;
    check("cfg_out_after_write", bus.cfg_out, exp);
  endtask

  // Square wave of period 64 cycles; the edge that samples it is cyc+1, pulse 3 later.
  task automatic ref_burst(input int n, output int last);
    last = 0;
    for (int i = 0; i < n; i++) begin
      ext_ref = 1'b1;
      last = cyc + 4;
      exp_q.push_back(last);
      #320;
      ext_ref = 1'b0;
      #320;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int k;
    int r;
    int t;
    int p;
    int a;
    int plast;

    rst = 1'b1;
    ext_ref = 1'b0;
    bus.set_cfg = 1'b0;
    bus.data_in = 32'd0;

    // Reset state and default INTERNAL /64 operation.
    wait_until(3);
    check("reset_cfg_out", bus.cfg_out, 32'h0000_4000);
    check("reset_ext_lost", {31'd0, bus.ext_lost}, 32'd0);
    check("reset_pulse", {31'd0, bus.time_pulse}, 32'd0);
    rst = 1'b0;
    r = cyc;
    exp_q.push_back(r + 64);
    exp_q.push_back(r + 128);
    exp_q.push_back(r + 192);
    drain(r + 192);

    // div 10.5: periods alternate 10/11.
    cfg_write(32'h0000_0A80, 32'h0000_0A80, k);
    t = k;
    p = 10;
    a = 0;
    for (int i = 0; i < 21; i++) begin
      t += p;
      exp_q.push_back(t);
      a += 128;
      p = 10 + (a >> 8);
      a &= 255;
    end
    drain(k + 220);

    // div 0 clamps to 2.
    cfg_write(32'h0000_0000, 32'h0000_0200, k);
    for (int j = 1; j <= 10; j++) exp_q.push_back(k + 2 * j);
    drain(k + 20);

    // This write lands on a wrap cycle; its pulse must be suppressed.
    cfg_write(32'h8000_4000, 32'h8000_4000, k);
    wait_until(k + 200);
    drain(k + 200);

    // EXTERNAL with a running reference.
    cfg_write(32'h4000_4000, 32'h4000_4000, k);
    #27;
    ref_burst(4, plast);
    check("ext_lost_locked", {31'd0, bus.ext_lost}, 32'd0);

    // Reference stops: fallback on the 2nd wrap, pulse from that wrap kept.
    exp_q.push_back(plast + 128);
    exp_q.push_back(plast + 192);
    exp_q.push_back(plast + 256);
    wait_until(plast + 127);
    check("ext_lost_before", {31'd0, bus.ext_lost}, 32'd0);
    wait_until(plast + 128);
    check("ext_lost_set", {31'd0, bus.ext_lost}, 32'd1);
    check("cfg_out_lost", bus.cfg_out, 32'h6000_4000);
    drain(plast + 256);

    // Reference returns: edges drive pulses again, ext_lost is sticky.
    wait_until(plast + 260);
    #27;
    ref_burst(2, plast);
    check("ext_lost_sticky", {31'd0, bus.ext_lost}, 32'd1);
    drain(plast);
    cfg_write(32'h4000_4000, 32'h4000_4000, k);
    check("ext_lost_cleared", {31'd0, bus.ext_lost}, 32'd0);

    // Reset asserted on the wrap edge drops the pulse and restores defaults.
    cfg_write(32'h0000_0A40, 32'h0000_0A40, k);
    wait_until(k + 9);
    rst = 1'b1;
    wait_until(k + 10);
    check("rst_drop_pulse", {31'd0, bus.time_pulse}, 32'd0);
    check("rst_cfg_out", bus.cfg_out, 32'h0000_4000);
    wait_until(k + 11);
    rst = 1'b0;
    r = cyc;
    exp_q.push_back(r + 64);
    exp_q.push_back(r + 128);
    drain(r + 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
